// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: command opcodes and sequencer states.
package gpio_pkg;

    localparam logic [1:0] OP_SET_OUT = 2'd0;
    localparam logic [1:0] OP_SET_OE  = 2'd1;
    localparam logic [1:0] OP_SET_OD  = 2'd2;
    localparam logic [1:0] OP_PULSE   = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// One-bit input synchroniser with registered rise/fall flags.
// Pad to flag latency is SYNC_STAGES+1 clock edges.
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   rise_reg;
    logic                   fall_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
            fall_reg <= ~sync_reg[SYNC_STAGES-1] & prev_reg;
        end
    end

    assign q    = sync_reg[SYNC_STAGES-1];
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/trellis_io_model.sv
// Behavioural stand-in for the ECP5 TRELLIS_IO cell, used in simulation only;
// synthesis takes the real cell from the vendor library instead of this file.
module TRELLIS_IO #(
    parameter string DIR = "INPUT"
) (
    inout  wire  B,
    input  logic I,
    input  logic T,
    output logic O
);

    localparam bit CAN_DRIVE = (DIR != "INPUT");

    assign B = (CAN_DRIVE && !T) ? I : 1'bz;
    assign O = B;

endmodule

// File: rtl/trellis_gpio_bank.sv
// Bank of WIDTH bidirectional ECP5 pins with push-pull/open-drain drive,
// a valid/ready command port, a timed pulse sequencer and synchronised inputs.
module trellis_gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             busy,
    output logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    inout  wire  [WIDTH-1:0] pin_io
);

    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("trellis_gpio_bank: WIDTH must be within 1..32");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("trellis_gpio_bank: SYNC_STAGES must be at least 2");
        end
        if (PULSE_CYCLES < 1) begin : g_bad_pulse
            $error("trellis_gpio_bank: PULSE_CYCLES must be at least 1");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] val,
                                               input logic [WIDTH-1:0] mask);
        return (cur & ~mask) | (val & mask);
    endfunction

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   out_reg, out_next;
    logic [WIDTH-1:0]   oe_reg, oe_next;
    logic [WIDTH-1:0]   od_reg, od_next;
    logic [WIDTH-1:0]   save_reg, save_next;
    logic [WIDTH-1:0]   pulse_mask_reg, pulse_mask_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               accept;

    logic [WIDTH-1:0]   drive;
    logic [WIDTH-1:0]   pad_t;
    logic [WIDTH-1:0]   pad_i;
    logic [WIDTH-1:0]   pad_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            out_reg        <= '0;
            oe_reg         <= '0;
            od_reg         <= '0;
            save_reg       <= '0;
            pulse_mask_reg <= '0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            out_reg        <= out_next;
            oe_reg         <= oe_next;
            od_reg         <= od_next;
            save_reg       <= save_next;
            pulse_mask_reg <= pulse_mask_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        state_next      = state_reg;
        out_next        = out_reg;
        oe_next         = oe_reg;
        od_next         = od_reg;
        save_next       = save_reg;
        pulse_mask_next = pulse_mask_reg;
        cnt_next        = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_SET_OUT: out_next = merge(out_reg, cmd_data, cmd_mask);
                        OP_SET_OE:  oe_next  = merge(oe_reg, cmd_data, cmd_mask);
                        OP_SET_OD:  od_next  = merge(od_reg, cmd_data, cmd_mask);
                        OP_PULSE: begin
                            save_next       = out_reg;
                            pulse_mask_next = cmd_mask;
                            out_next        = merge(out_reg, cmd_data, cmd_mask);
                            cnt_next        = CNT_W'(PULSE_CYCLES - 1);
                            state_next      = ST_PULSE;
                        end
                    endcase
                end
            end
            ST_PULSE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    // Only the pulsed bits return to their saved value.
                    out_next   = merge(out_reg, save_reg, pulse_mask_reg);
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_reg == ST_IDLE);
        busy      = (state_reg == ST_PULSE);
    end

    // Open-drain pins only ever pull low; a high output floats.
    assign drive = oe_reg & (~od_reg | ~out_reg);
    assign pad_t = ~drive;
    assign pad_i = out_reg & ~od_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
            TRELLIS_IO #(
                .DIR("BIDIR")
            ) u_io (
                .B(pin_io[gi]),
                .I(pad_i[gi]),
                .T(pad_t[gi]),
                .O(pad_o[gi])
            );

            gpio_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk  (clk),
                .rst_n(rst_n),
                .d    (pad_o[gi]),
                .q    (pin_in[gi]),
                .rise (rise[gi]),
                .fall (fall[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_trellis_gpio_bank.sv
// Directed bench for trellis_gpio_bank (WIDTH=8, SYNC_STAGES=2, PULSE_CYCLES=4)
// with a pull-up on every pad and an optional external driver per pin.
module tb_trellis_gpio_bank;
    import gpio_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_mask = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       busy;
    logic [7:0] pin_in;
    logic [7:0] rise;
    logic [7:0] fall;
    wire  [7:0] pin_io;

    logic [7:0] ext_en = 8'h00;
    logic [7:0] ext_val = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trellis_gpio_bank #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .PULSE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_mask (cmd_mask),
        .cmd_data (cmd_data),
        .busy     (busy),
        .pin_in   (pin_in),
        .rise     (rise),
        .fall     (fall),
        .pin_io   (pin_io)
    );

    // Board side of each pad: an external driver, else a pull-up that only
    // asserts itself while the bank has released the pin.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
        assign pin_io[gi] = ext_en[gi]        ? ext_val[gi] :
                            dut.pad_t[gi]     ? 1'b1        : 1'bz;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] mask, input logic [7:0] data);
        check1("ready_before_cmd", cmd_ready, 1'b1);
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        $display("cmd op=%0d mask=%h data=%h pads=%h", op, mask, data, pin_io);
    endtask

    initial begin
        // Reset, then idle: every pad released and pulled high
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check8("reset_pad_t", dut.pad_t, 8'hFF);
        check8("reset_pads", pin_io, 8'hFF);
        check1("reset_ready", cmd_ready, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check8("reset_rise", rise, 8'h00);
        check8("reset_fall", fall, 8'h00);
        check8("reset_pin_in", pin_in, 8'h00);
        tick();
        check8("pullup_pin_in", pin_in, 8'hFF);
        check8("pullup_rise_early", rise, 8'h00);
        tick();
        check8("pullup_rise", rise, 8'hFF);
        tick();
        check8("pullup_rise_end", rise, 8'h00);

        // Enable all outputs (driving 0), then set the low nibble to 0x5
        send(OP_SET_OE, 8'hFF, 8'hFF);
        check8("oe_pads", pin_io, 8'h00);
        check8("oe_pad_t", dut.pad_t, 8'h00);
        send(OP_SET_OUT, 8'h0F, 8'h05);
        check8("out_pads", pin_io, 8'h05);
        tick();
        tick();
        check8("out_pin_in", pin_in, 8'h05);
        check8("out_fall", fall, 8'hFF);
        tick();
        check8("out_rise", rise, 8'h05);
        check8("out_fall_end", fall, 8'h00);

        // Open-drain on pin 0 while it holds 1: released, pull-up reads 1
        send(OP_SET_OD, 8'h01, 8'h01);
        check8("od_pad_t", dut.pad_t, 8'h01);
        check8("od_pad_i", dut.pad_i, 8'h04);
        check8("od_pads", pin_io, 8'h05);
        send(OP_SET_OUT, 8'h01, 8'h00);
        check8("od_low_pad_t", dut.pad_t, 8'h00);
        check8("od_low_pads", pin_io, 8'h04);

        // Pulse pins 7 and 0 from a clean all-low push-pull state
        send(OP_SET_OD, 8'hFF, 8'h00);
        send(OP_SET_OUT, 8'hFF, 8'h00);
        check8("pre_pulse_pads", pin_io, 8'h00);
        send(OP_PULSE, 8'h81, 8'h81);
        cmd_op    = OP_SET_OUT;
        cmd_mask  = 8'h02;
        cmd_data  = 8'h02;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            $display("pulse cycle %0d pads=%h busy=%b ready=%b", i, pin_io, busy, cmd_ready);
            check8("pulse_pads", pin_io, 8'h81);
            check1("pulse_busy", busy, 1'b1);
            check1("pulse_ready", cmd_ready, 1'b0);
            tick();
        end
        check8("pulse_end_pads", pin_io, 8'h00);
        check1("pulse_end_busy", busy, 1'b0);
        check1("pulse_end_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check8("held_cmd_pads", pin_io, 8'h02);

        // Release pin 4 and drive it externally 0 -> 1 -> 0
        send(OP_SET_OE, 8'h10, 8'h00);
        check8("z_pin_pad_t", dut.pad_t, 8'h10);
        check8("z_pin_pads", pin_io, 8'h12);
        ext_en  = 8'h10;
        ext_val = 8'h00;
        repeat (5) tick();
        check8("ext_low_pin_in", pin_in, 8'h02);
        ext_val = 8'h10;
        tick();
        tick();
        check8("ext_rise_early", rise, 8'h00);
        tick();
        $display("ext rise pin_in=%h rise=%h fall=%h", pin_in, rise, fall);
        check8("ext_rise", rise, 8'h10);
        check8("ext_rise_nofall", fall, 8'h00);
        tick();
        check8("ext_rise_width", rise, 8'h00);
        ext_val = 8'h00;
        tick();
        tick();
        check8("ext_fall_early", fall, 8'h00);
        tick();
        $display("ext fall pin_in=%h rise=%h fall=%h", pin_in, rise, fall);
        check8("ext_fall", fall, 8'h10);
        check8("ext_fall_norise", rise, 8'h00);
        tick();
        check8("ext_fall_width", fall, 8'h00);
        ext_en = 8'h00;

        // Reset during the second pulse cycle aborts the pulse
        send(OP_PULSE, 8'h0F, 8'h0F);
        check8("abort_pulse_c1", pin_io, 8'h1F);
        tick();
        check8("abort_pulse_c2", pin_io, 8'h1F);
        check1("abort_busy_c2", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        $display("abort pads=%h busy=%b ready=%b", pin_io, busy, cmd_ready);
        check8("abort_pad_t", dut.pad_t, 8'hFF);
        check8("abort_pads", pin_io, 8'hFF);
        check8("abort_out_reg", dut.out_reg, 8'h00);
        check1("abort_busy", busy, 1'b0);
        check1("abort_ready", cmd_ready, 1'b1);
        rst_n = 1'b1;
        tick();
        check1("post_abort_ready", cmd_ready, 1'b1);
        check8("post_abort_pads", pin_io, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
